// File: rtl/host_cmd_sequencer_if.sv
// host_cmd_sequencer_if
//   Groups the byte-stream and command/reply handshakes around the host
//   command sequencer.
//
// Handshake rule (applies to cmd_* and tx_*): the producer raises valid and
// holds its payload stable until the cycle where valid && ready are both
// high. The transfer happens on that clock edge. valid never depends
// combinationally on ready. rx_valid is a bare one-cycle strobe with no
// ready: a byte offered while the sequencer cannot take it is lost.
//
// Signals
//   rx_valid/rx_data        : UART receive byte strobe (into sequencer)
//   cmd_valid/ready/code/arg: command handed to sd_fsm
//   cmd_done/cmd_err        : completion pulse from sd_fsm
//   tx_valid/ready/data     : one-byte reply to the UART transmitter
//
// Modports
//   master : the sequencer side
//   slave  : the environment (UART + sd_fsm)
interface host_cmd_sequencer_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_code;
  logic [31:0] cmd_arg;
  logic        cmd_done;
  logic        cmd_err;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;

  modport master (
    input  rx_valid, rx_data,
    output cmd_valid, cmd_code, cmd_arg,
    input  cmd_ready, cmd_done, cmd_err,
    output tx_valid, tx_data,
    input  tx_ready
  );

  modport slave (
    output rx_valid, rx_data,
    input  cmd_valid, cmd_code, cmd_arg,
    output cmd_ready, cmd_done, cmd_err,
    input  tx_valid, tx_data,
    output tx_ready
  );
endinterface

// File: rtl/host_cmd_sequencer.sv
// host_cmd_sequencer
//   Frames host UART bytes (SYNC, OP, A3, A2, A1, A0, CS) into SD host
//   commands. It issues one command at a time to sd_fsm, waits for
//   completion, and answers the host with a single ACK or NAK byte.
//   CS is the XOR of OP and the four argument bytes. The argument is
//   big-endian.
//
// Ports
//   ex_clk     : system clock
//   ex_resetn  : asynchronous active-low reset
//   host       : host_cmd_sequencer_if.master (rx / cmd / tx handshakes)
//   busy       : high whenever the sequencer is not hunting for SYNC
//   overrun    : sticky; a byte arrived while a command or reply was pending
//   err_count  : saturating count of NAK bytes accepted by the transmitter
//   state_dbg  : current FSM state encoding (see state_e)
//
// Optional build macro
//   TIMEOUT_EN : when defined, a partial frame is abandoned if no byte
//                arrives within TIMEOUT_CYCLES cycles. The abandoned frame
//                counts as an error, and no reply is sent.
module host_cmd_sequencer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] ACK_BYTE  = 8'h06,
  parameter logic [7:0] NAK_BYTE  = 8'h15
`ifdef TIMEOUT_EN
  , parameter int       TIMEOUT_CYCLES = 50000
`endif
) (
  input  logic                        ex_clk,
  input  logic                        ex_resetn,
  host_cmd_sequencer_if.master        host,
  output logic                        busy,
  output logic                        overrun,
  output logic [7:0]                  err_count,
  output logic [2:0]                  state_dbg
);

  typedef enum logic [2:0] {
    HUNT   = 3'd0,
    OPCODE = 3'd1,
    ARG    = 3'd2,
    CSUM   = 3'd3,
    ISSUE  = 3'd4,
    WAIT   = 3'd5,
    REPLY  = 3'd6
  } state_e;

  state_e      state_q,     state_d;
  logic [7:0]  op_q,        op_d;
  logic [7:0]  cs_q,        cs_d;
  logic [1:0]  idx_q,       idx_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [3:0]  cmd_code_q,  cmd_code_d;
  logic [31:0] cmd_arg_q,   cmd_arg_d;
  logic        tx_valid_q,  tx_valid_d;
  logic [7:0]  tx_data_q,   tx_data_d;
  logic        overrun_q,   overrun_d;
  logic [7:0]  err_q,       err_d;
`ifdef TIMEOUT_EN
  logic [15:0] tmo_q,       tmo_d;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cs_d        = cs_q;
    idx_d       = idx_q;
    cmd_valid_d = cmd_valid_q;
    cmd_code_d  = cmd_code_q;
    cmd_arg_d   = cmd_arg_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    overrun_d   = overrun_q;
    err_d       = err_q;
`ifdef TIMEOUT_EN
    tmo_d       = 16'd0;
`endif

    case (state_q)
      HUNT: begin
        if (host.rx_valid && host.rx_data == SYNC_BYTE) begin
          cs_d    = 8'h00;
          idx_d   = 2'd0;
          state_d = OPCODE;
        end
      end

      OPCODE: begin
        if (host.rx_valid) begin
          op_d    = host.rx_data;
          cs_d    = host.rx_data;
          idx_d   = 2'd0;
          state_d = ARG;
        end
      end

      ARG: begin
        // Shifting in at the LSB side leaves the first byte (A3) in
        // bits [31:24] after four bytes, giving the big-endian order.
        // SYNC-valued bytes here are plain data.
        if (host.rx_valid) begin
          cmd_arg_d = {cmd_arg_q[23:0], host.rx_data};
          cs_d      = cs_q ^ host.rx_data;
          idx_d     = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = CSUM;
        end
      end

      CSUM: begin
        if (host.rx_valid) begin
          if (host.rx_data == cs_q && op_q[7:4] == 4'h0) begin
            cmd_code_d  = op_q[3:0];
            cmd_valid_d = 1'b1;
            state_d     = ISSUE;
          end else begin
            tx_data_d  = NAK_BYTE;
            tx_valid_d = 1'b1;
            state_d    = REPLY;
          end
        end
      end

      ISSUE: begin
        if (host.rx_valid) overrun_d = 1'b1;
        // cmd_done in this state belongs to no accepted command; ignore it.
        if (host.cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = WAIT;
        end
      end

      WAIT: begin
        if (host.rx_valid) overrun_d = 1'b1;
        if (host.cmd_done) begin
          tx_data_d  = host.cmd_err ? NAK_BYTE : ACK_BYTE;
          tx_valid_d = 1'b1;
          state_d    = REPLY;
        end
      end

      REPLY: begin
        if (host.rx_valid) overrun_d = 1'b1;
        if (host.tx_ready) begin
          tx_valid_d = 1'b0;
          if (tx_data_q == NAK_BYTE && err_q != 8'hFF) err_d = err_q + 8'd1;
          state_d = HUNT;
        end
      end

      default: state_d = HUNT;
    endcase

`ifdef TIMEOUT_EN
    // The counter runs only while a frame is being parsed, and every
    // received byte reloads it. Expiry drops the frame silently but
    // still counts it as an error.
    if (state_q == OPCODE || state_q == ARG || state_q == CSUM) begin
      if (host.rx_valid) begin
        tmo_d = 16'd0;
      end else if (tmo_q == TMO_LAST) begin
        tmo_d   = 16'd0;
        state_d = HUNT;
        if (err_q != 8'hFF) err_d = err_q + 8'd1;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      state_q     <= HUNT;
      op_q        <= 8'h00;
      cs_q        <= 8'h00;
      idx_q       <= 2'd0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= 4'h0;
      cmd_arg_q   <= 32'h0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      overrun_q   <= 1'b0;
      err_q       <= 8'h00;
`ifdef TIMEOUT_EN
      tmo_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cs_q        <= cs_d;
      idx_q       <= idx_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      cmd_arg_q   <= cmd_arg_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      overrun_q   <= overrun_d;
      err_q       <= err_d;
`ifdef TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign host.cmd_valid = cmd_valid_q;
  assign host.cmd_code  = cmd_code_q;
  assign host.cmd_arg   = cmd_arg_q;
  assign host.tx_valid  = tx_valid_q;
  assign host.tx_data   = tx_data_q;
  assign busy           = (state_q != HUNT);
  assign overrun        = overrun_q;
  assign err_count      = err_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_host_cmd_sequencer.sv
module tb_host_cmd_sequencer;

  localparam logic [2:0] S_HUNT  = 3'd0;
  localparam logic [2:0] S_ARG   = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_REPLY = 3'd6;

  // clock / reset
  logic ex_clk = 1'b0;
  logic ex_resetn;
  always #5 ex_clk = ~ex_clk;

  host_cmd_sequencer_if bus ();
  logic       busy;
  logic       overrun;
  logic [7:0] err_count;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

`ifdef TIMEOUT_EN
  host_cmd_sequencer #(.TIMEOUT_CYCLES(100)) dut (
`else
  host_cmd_sequencer dut (
`endif
    .ex_clk    (ex_clk),
    .ex_resetn (ex_resetn),
    .host      (bus),
    .busy      (busy),
    .overrun   (overrun),
    .err_count (err_count),
    .state_dbg (state_dbg)
  );

  // driver tasks: inputs change on the falling edge and outputs are
  // sampled there too, away from the active edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge ex_clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge ex_clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] arg, input logic [7:0] cs);
    send_byte(8'hA5);
    send_byte(op);
    send_byte(arg[31:24]);
    send_byte(arg[23:16]);
    send_byte(arg[15:8]);
    send_byte(arg[7:0]);
    send_byte(cs);
  endtask

  // Reply acceptance: one tx_ready cycle, then the bus must be idle.
  task automatic accept_reply(input string name);
    bus.tx_ready = 1'b1;
    @(negedge ex_clk);
    bus.tx_ready = 1'b0;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL %s_tx_drop: got %b want 0", name, bus.tx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle: busy got %b want 0", name, busy); end
  endtask

  // Accept the issued command, then complete it and take the reply.
  task automatic complete_cmd(input logic err, input logic [7:0] exp_tx, input string name);
    bus.cmd_ready = 1'b1;
    @(negedge ex_clk);
    bus.cmd_ready = 1'b0;
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL %s_hs: cmd_valid got %b want 0", name, bus.cmd_valid); end
    checks++; if (state_dbg !== S_WAIT) begin errors++; $display("FAIL %s_wait: state got %0d want %0d", name, state_dbg, S_WAIT); end
    repeat (3) @(negedge ex_clk);
    bus.cmd_done = 1'b1;
    bus.cmd_err  = err;
    @(negedge ex_clk);
    bus.cmd_done = 1'b0;
    bus.cmd_err  = 1'b0;
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL %s_tx_valid: got %b want 1", name, bus.tx_valid); end
    checks++; if (bus.tx_data !== exp_tx) begin errors++; $display("FAIL %s_tx_data: got %h want %h", name, bus.tx_data, exp_tx); end
    repeat (2) @(negedge ex_clk);
    checks++; if (bus.tx_data !== exp_tx) begin errors++; $display("FAIL %s_tx_hold: got %h want %h", name, bus.tx_data, exp_tx); end
    accept_reply(name);
  endtask

  task automatic check_issue(input logic [3:0] code, input logic [31:0] arg, input string name);
    checks++; if (bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL %s_cmd_valid: got %b want 1", name, bus.cmd_valid); end
    checks++; if (bus.cmd_code !== code) begin errors++; $display("FAIL %s_cmd_code: got %h want %h", name, bus.cmd_code, code); end
    checks++; if (bus.cmd_arg !== arg) begin errors++; $display("FAIL %s_cmd_arg: got %h want %h", name, bus.cmd_arg, arg); end
    checks++; if (state_dbg !== S_ISSUE) begin errors++; $display("FAIL %s_state: got %0d want %0d", name, state_dbg, S_ISSUE); end
  endtask

  task automatic test_reset();
    ex_resetn     = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.cmd_ready = 1'b0;
    bus.cmd_done  = 1'b0;
    bus.cmd_err   = 1'b0;
    bus.tx_ready  = 1'b0;
    repeat (3) @(negedge ex_clk);
    checks++; if (state_dbg !== S_HUNT) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b want 0", bus.cmd_valid); end
    checks++; if (bus.cmd_code !== 4'h0) begin errors++; $display("FAIL reset_cmd_code: got %h want 0", bus.cmd_code); end
    checks++; if (bus.cmd_arg !== 32'h0) begin errors++; $display("FAIL reset_cmd_arg: got %h want 0", bus.cmd_arg); end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_err_count: got %h want 00", err_count); end
    ex_resetn = 1'b1;
    @(negedge ex_clk);
  endtask

  // 01 ^ 00 ^ 00 ^ 01 ^ AA = AA
  task automatic test_good_frame();
    send_frame(8'h01, 32'h0000_01AA, 8'hAA);
    check_issue(4'h1, 32'h0000_01AA, "good");
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy: got %b want 1", busy); end
    complete_cmd(1'b0, 8'h06, "good");
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL good_err_count: got %h want 00", err_count); end
  endtask

  // 02 ^ 12 ^ 34 ^ 56 ^ 78 = 0A, so FF is wrong
  task automatic test_bad_checksum();
    send_frame(8'h02, 32'h1234_5678, 8'hFF);
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL badcs_cmd_valid: got %b want 0", bus.cmd_valid); end
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL badcs_tx_valid: got %b want 1", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'h15) begin errors++; $display("FAIL badcs_tx_data: got %h want 15", bus.tx_data); end
    checks++; if (state_dbg !== S_REPLY) begin errors++; $display("FAIL badcs_state: got %0d want %0d", state_dbg, S_REPLY); end
    accept_reply("badcs");
    checks++; if (err_count !== 8'h01) begin errors++; $display("FAIL badcs_err_count: got %h want 01", err_count); end
    // 05 ^ DE ^ AD ^ BE ^ EF = 27
    send_frame(8'h05, 32'hDEAD_BEEF, 8'h27);
    check_issue(4'h5, 32'hDEAD_BEEF, "after_bad");
    complete_cmd(1'b0, 8'h06, "after_bad");
  endtask

  // SYNC value inside the argument is ordinary data: 01 ^ A5 = A4
  task automatic test_sync_as_data();
    send_frame(8'h01, 32'hA500_0000, 8'hA4);
    check_issue(4'h1, 32'hA500_0000, "syncdata");
    complete_cmd(1'b0, 8'h06, "syncdata");
  endtask

  // 07 ^ 11 ^ 22 ^ 33 ^ 44 = 43
  task automatic test_backpressure();
    send_frame(8'h07, 32'h1122_3344, 8'h43);
    repeat (20) @(negedge ex_clk);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    check_issue(4'h7, 32'h1122_3344, "bp");
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun: got %b want 1", overrun); end
    // done arriving with the handshake must be ignored
    bus.cmd_ready = 1'b1;
    bus.cmd_done  = 1'b1;
    @(negedge ex_clk);
    bus.cmd_ready = 1'b0;
    bus.cmd_done  = 1'b0;
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL bp_hs: cmd_valid got %b want 0", bus.cmd_valid); end
    checks++; if (state_dbg !== S_WAIT) begin errors++; $display("FAIL bp_done_ignored: state got %0d want %0d", state_dbg, S_WAIT); end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL bp_no_tx: got %b want 0", bus.tx_valid); end
    repeat (2) @(negedge ex_clk);
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL bp_single_hs: cmd_valid got %b want 0", bus.cmd_valid); end
    bus.cmd_done = 1'b1;
    @(negedge ex_clk);
    bus.cmd_done = 1'b0;
    checks++; if (bus.tx_data !== 8'h06) begin errors++; $display("FAIL bp_tx_data: got %h want 06", bus.tx_data); end
    accept_reply("bp");
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_noise_opcode();
    send_byte(8'h00);
    send_byte(8'hFF);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noise_busy: got %b want 0", busy); end
    send_frame(8'h13, 32'h0, 8'h13);
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL opcode_cmd_valid: got %b want 0", bus.cmd_valid); end
    checks++; if (bus.tx_data !== 8'h15) begin errors++; $display("FAIL opcode_tx_data: got %h want 15", bus.tx_data); end
    accept_reply("opcode");
    checks++; if (err_count !== 8'h02) begin errors++; $display("FAIL opcode_err_count: got %h want 02", err_count); end
    // 06 ^ 00 ^ 00 ^ 00 ^ 01 = 07
    send_frame(8'h06, 32'h0000_0001, 8'h07);
    check_issue(4'h6, 32'h0000_0001, "cmderr");
    complete_cmd(1'b1, 8'h15, "cmderr");
    checks++; if (err_count !== 8'h03) begin errors++; $display("FAIL cmderr_err_count: got %h want 03", err_count); end
  endtask

  task automatic test_reset_midframe();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    #2 ex_resetn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun: got %b want 0", overrun); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL midrst_err_count: got %h want 00", err_count); end
    checks++; if (bus.cmd_code !== 4'h0) begin errors++; $display("FAIL midrst_cmd_code: got %h want 0", bus.cmd_code); end
    checks++; if (bus.cmd_arg !== 32'h0) begin errors++; $display("FAIL midrst_cmd_arg: got %h want 0", bus.cmd_arg); end
    @(negedge ex_clk);
    ex_resetn = 1'b1;
    send_frame(8'h03, 32'h0, 8'h03);
    check_issue(4'h3, 32'h0, "postrst");
    complete_cmd(1'b0, 8'h06, "postrst");
  endtask

`ifdef TIMEOUT_EN
  task automatic test_partial_frame();
    send_byte(8'hA5);
    send_byte(8'h04);
    repeat (101) @(negedge ex_clk);
    checks++; if (state_dbg !== S_HUNT) begin errors++; $display("FAIL tmo_state: got %0d want 0", state_dbg); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b want 0", busy); end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL tmo_tx_valid: got %b want 0", bus.tx_valid); end
    checks++; if (err_count !== 8'h01) begin errors++; $display("FAIL tmo_err_count: got %h want 01", err_count); end
  endtask
`else
  task automatic test_partial_frame();
    send_byte(8'hA5);
    send_byte(8'h04);
    repeat (200) @(negedge ex_clk);
    checks++; if (state_dbg !== S_ARG) begin errors++; $display("FAIL partial_state: got %0d want %0d", state_dbg, S_ARG); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL partial_busy: got %b want 1", busy); end
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h04);
    check_issue(4'h4, 32'h0, "partial");
    complete_cmd(1'b0, 8'h06, "partial");
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_sync_as_data();
    test_backpressure();
    test_noise_opcode();
    test_reset_midframe();
    test_partial_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
